int_divider: RTL

Iterative radix-2 integer divider serving the RV32M DIV/DIVU/REM/REMU instructions. It is the responder on the `div_in`/`div_out` interface that the execute stage drives. The block accepts a start request, runs one quotient bit per cycle, and returns a one-cycle `ready` pulse with the selected quotient or remainder. The execute stage stalls until that pulse arrives.

---
 rtl/int_divider.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/int_divider.sv
`default_nettype none
// ============================================================================
// Module   : int_divider
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Accepts one request while idle, produces one quotient bit per
//            cycle and returns a single-cycle ready pulse with the selected
//            quotient or remainder. A zero divisor takes a one-cycle fast path.
// Ports    : clock          rising-edge clock
//            reset          synchronous, active-high
//            div_in_enable  start request (sampled only while idle)
//            div_in_rdata1  dividend
//            div_in_rdata2  divisor
//            div_in_div_op  one-hot op: [0]=div [1]=divu [2]=rem [3]=remu
//            div_out_ready  result valid, one cycle per accepted request
//            div_out_result registered result, held until the next result
// Revision : 1.0 - initial release
// ============================================================================
module int_divider #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            div_in_enable,
  input  logic [XLEN-1:0] div_in_rdata1,
  input  logic [XLEN-1:0] div_in_rdata2,
  input  logic [3:0]      div_in_div_op,
  output logic            div_out_ready,
  output logic [XLEN-1:0] div_out_result
);

  localparam int CW      = $clog2(XLEN);
  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_next;

  // Operation context captured at the accept edge
  logic            want_rem;
  logic            negq;
  logic            negr;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [CW-1:0]   count;

  // Request decode
  logic            accept;
  logic            in_signed;
  logic            in_want_rem;
  logic            sign1;
  logic            sign2;
  logic            div_by_zero;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;

  // One restoring step
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  logic            trial_neg;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] final_quo;
  logic [XLEN-1:0] final_rem;

  assign accept      = (state == IDLE) && div_in_enable;
  assign in_signed   = div_in_div_op[OP_DIV] | div_in_div_op[OP_REM];
  // A malformed multi-hot op prefers the quotient.
  assign in_want_rem = (div_in_div_op[OP_REM] | div_in_div_op[OP_REMU]) &
                       ~(div_in_div_op[OP_DIV] | div_in_div_op[OP_DIVU]);
  assign sign1       = div_in_rdata1[XLEN-1];
  assign sign2       = div_in_rdata2[XLEN-1];
  assign div_by_zero = (div_in_rdata2 == '0);
  assign abs1        = (in_signed && sign1) ? -div_in_rdata1 : div_in_rdata1;
  assign abs2        = (in_signed && sign2) ? -div_in_rdata2 : div_in_rdata2;

  // The shifted partial remainder can reach 2*divisor-1, so the trial
  // subtraction carries one extra bit above it to expose a true sign.
  assign rem_sh    = {rem, quo[XLEN-1]};
  assign trial     = {1'b0, rem_sh} - {2'b00, divisor};
  assign trial_neg = trial[XLEN+1];
  assign rem_next  = trial_neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next  = {quo[XLEN-2:0], ~trial_neg};

  // Negation wraps, so -2^(XLEN-1) / -1 naturally yields -2^(XLEN-1).
  assign final_quo = negq ? -quo_next : quo_next;
  assign final_rem = negr ? -rem_next : rem_next;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (div_in_enable) begin
          state_next = div_by_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: ready comes from the state register only
  always_comb begin
    div_out_ready = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      want_rem       <= 1'b0;
      negq           <= 1'b0;
      negr           <= 1'b0;
      divisor        <= '0;
      quo            <= '0;
      rem            <= '0;
      count          <= '0;
      div_out_result <= '0;
    end else if (accept) begin
      want_rem <= in_want_rem;
      negq     <= in_signed & (sign1 ^ sign2) & ~div_by_zero;
      negr     <= in_signed & sign1;
      divisor  <= abs2;
      quo      <= abs1;
      rem      <= '0;
      count    <= CW'(XLEN - 1);
      // Fast path goes straight to DONE, so the result is loaded now:
      // all-ones quotient, or the untouched dividend as remainder.
      if (div_by_zero) begin
        div_out_result <= in_want_rem ? div_in_rdata1 : '1;
      end
    end else if (state == BUSY) begin
      rem   <= rem_next;
      quo   <= quo_next;
      count <= count - CW'(1);
      if (count == '0) begin
        div_out_result <= want_rem ? final_rem : final_quo;
      end
    end
  end

endmodule
`default_nettype wire
